// File: rtl/sipo_frame_receiver_pkg.sv
// sipo_frame_receiver_pkg
//   Shared definitions for the serial frame receiver: FSM state encodings
//   and serial line levels.
//   Ports: none (package).
package sipo_frame_receiver_pkg;

   // FSM state encodings (2-bit, legacy-compatible values)
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   // Line idles low; the start bit is the opposite level, the stop bit is idle.
   localparam logic LINE_IDLE   = 1'b0;
   localparam logic START_LEVEL = ~LINE_IDLE;

endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg
//   Serial-in parallel-out shift register with a running XOR of every bit
//   shifted in since the last clear.
//   Ports:
//     clk  in   1      clock, all state on posedge
//     rst  in   1      asynchronous active-low reset
//     clr  in   1      clear contents and running parity
//     en   in   1      shift d in this cycle
//     d    in   1      serial data in
//     q    out  WIDTH  parallel contents
//     par  out  1      XOR of bits shifted in since clear
module sipo_shift_reg #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             d,
   output logic [WIDTH-1:0] q,
   output logic             par
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q   <= '0;
         par <= 1'b0;
      end else if (clr) begin
         q   <= '0;
         par <= 1'b0;
      end else if (en) begin
         // MSB_FIRST: earliest bit ends up in q[WIDTH-1]; otherwise in q[0].
         if (MSB_FIRST) q <= {q[WIDTH-2:0], d};
         else           q <= {d, q[WIDTH-1:1]};
         par <= par ^ d;
      end
   end

endmodule

// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver
//   Receive end of a one-bit-per-clock serial link. Detects a start bit,
//   shifts in WIDTH data bits, checks optional even parity and the stop bit,
//   and presents the recovered word on a valid/ready interface.
//   Ports:
//     clk          in   1      clock, all state on posedge
//     rst          in   1      asynchronous active-low reset
//     D            in   1      serial line, idle 0
//     Q_data       out  WIDTH  received word, stable while Q_valid=1
//     Q_valid      out  1      word available
//     Q_ready      in   1      consumer accepts when Q_valid && Q_ready
//     busy         out  1      receiver is inside a frame
//     parity_err   out  1      pulse: parity mismatch, frame dropped
//     frame_err    out  1      pulse: stop bit was 1, frame dropped
//     overrun_err  out  1      pulse: good frame lost, output buffer full
module sipo_frame_receiver
   import sipo_frame_receiver_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          PARITY_EN = 1'b1,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             D,
   output logic [WIDTH-1:0] Q_data,
   output logic             Q_valid,
   input  logic             Q_ready,
   output logic             busy,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun_err
);

   localparam int unsigned  CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             par_bad;
   logic             sr_clr;
   logic             sr_en;
   logic [WIDTH-1:0] sr_q;
   logic             sr_par;
   logic             buf_free;

   assign sr_clr   = (state == S_IDLE) && (D == START_LEVEL);
   assign sr_en    = (state == S_DATA);
   assign busy     = (state != S_IDLE);
   // Holding register can take a word if empty or being drained this cycle.
   assign buf_free = !Q_valid || Q_ready;

   sipo_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk (clk),
      .rst (rst),
      .clr (sr_clr),
      .en  (sr_en),
      .d   (D),
      .q   (sr_q),
      .par (sr_par)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         par_bad     <= 1'b0;
         Q_data      <= '0;
         Q_valid     <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;

         if (Q_valid && Q_ready) Q_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (D == START_LEVEL) begin
                  state   <= S_DATA;
                  cnt     <= '0;
                  par_bad <= 1'b0;
               end
            end
            S_DATA: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= PARITY_EN ? S_PARITY : S_STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_PARITY: begin
               // Even parity: data XOR parity bit must be 0.
               par_bad <= sr_par ^ D;
               state   <= S_STOP;
            end
            S_STOP: begin
               // Return to IDLE unconditionally: a 1 here is a bad stop bit,
               // never a start bit.
               state <= S_IDLE;
               if (D != LINE_IDLE) begin
                  frame_err <= 1'b1;
               end else if (PARITY_EN && par_bad) begin
                  parity_err <= 1'b1;
               end else if (buf_free) begin
                  Q_data  <= sr_q;
                  Q_valid <= 1'b1;
               end else begin
                  overrun_err <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// tb_sipo_frame_receiver
//   Scoreboard bench: two receivers (MSB-first and LSB-first) share one
//   serial line. Each driven frame pushes its expected outcome, arrival
//   cycle and word; a negedge monitor pops and compares on every output event.
//   Ports: none.
module tb_sipo_frame_receiver;

   localparam int K_WORD = 1;
   localparam int K_PAR  = 2;
   localparam int K_FRM  = 3;
   localparam int K_OVR  = 4;

   typedef struct {
      int         kind;
      logic [7:0] dm;
      logic [7:0] dl;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       D;
   logic       Q_ready;

   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid, a_busy, b_busy;
   logic       a_pe, b_pe, a_fe, b_fe, a_oe, b_oe;

   int   tests;
   int   fails;
   int   cyc;
   exp_t sb[$];

   logic a_pv, a_acc, b_pv, b_acc;

   sipo_frame_receiver #(
      .WIDTH     (8),
      .PARITY_EN (1'b1),
      .MSB_FIRST (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .D           (D),
      .Q_data      (a_data),
      .Q_valid     (a_valid),
      .Q_ready     (Q_ready),
      .busy        (a_busy),
      .parity_err  (a_pe),
      .frame_err   (a_fe),
      .overrun_err (a_oe)
   );

   sipo_frame_receiver #(
      .WIDTH     (8),
      .PARITY_EN (1'b1),
      .MSB_FIRST (1'b0)
   ) dut_lsb (
      .clk         (clk),
      .rst         (rst),
      .D           (D),
      .Q_data      (b_data),
      .Q_valid     (b_valid),
      .Q_ready     (Q_ready),
      .busy        (b_busy),
      .parity_err  (b_pe),
      .frame_err   (b_fe),
      .overrun_err (b_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   function automatic int ev_code(input logic nw, input logic pe, input logic fe, input logic oe);
      int n;
      n = int'(pe) + int'(fe) + int'(oe);
      if (n > 1 || (n == 1 && nw)) return 5;
      if (nw) return K_WORD;
      if (pe) return K_PAR;
      if (fe) return K_FRM;
      if (oe) return K_OVR;
      return 0;
   endfunction

   // Pre-edge capture of valid and handshake, for detecting newly presented words.
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      a_pv  <= a_valid;
      a_acc <= a_valid && Q_ready;
      b_pv  <= b_valid;
      b_acc <= b_valid && Q_ready;
   end

   always @(negedge clk) begin
      int   ea, eb;
      exp_t e;
      if (rst) begin
         ea = ev_code(a_valid && (!a_pv || a_acc), a_pe, a_fe, a_oe);
         eb = ev_code(b_valid && (!b_pv || b_acc), b_pe, b_fe, b_oe);
         if (ea != 0 || eb != 0) begin
            if (sb.size() == 0) begin
               check("unexpected_event", 32'(ea * 8 + eb), 32'd0);
            end else begin
               e = sb.pop_front();
               check("event_msb", 32'(ea), 32'(e.kind));
               check("event_lsb", 32'(eb), 32'(e.kind));
               check("latency", 32'(cyc), 32'(e.cyc));
               check("busy_at_end_msb", 32'(a_busy), 32'd0);
               check("busy_at_end_lsb", 32'(b_busy), 32'd0);
               if (e.kind == K_WORD) begin
                  check("data_msb", 32'(a_data), 32'(e.dm));
                  check("data_lsb", 32'(b_data), 32'(e.dl));
               end
            end
         end
      end
   end

   // Frame bits sent first to last: start, w[7]..w[0], parity, stop.
   task automatic send_frame(input logic [7:0] w, input logic par_flip, input logic stop_bit,
                             input int kind, input logic rdy_at_stop);
      logic [10:0] bits;
      exp_t        e;
      bits   = {1'b1, w, (^w) ^ par_flip, stop_bit};
      e.kind = kind;
      e.dm   = w;
      e.dl   = rev8(w);
      e.cyc  = cyc + 11;
      sb.push_back(e);
      for (int i = 10; i >= 0; i--) begin
         D = bits[i];
         if (i == 0 && rdy_at_stop) Q_ready = 1'b1;
         @(negedge clk);
      end
      if (rdy_at_stop) Q_ready = 1'b0;
      D = 1'b0;
   endtask

   initial begin
      logic [7:0] part;
      tests   = 0;
      fails   = 0;
      cyc     = 0;
      rst     = 1'b0;
      D       = 1'b0;
      Q_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_valid", 32'(a_valid), 32'd0);
      check("rst_data", 32'(a_data), 32'd0);
      check("rst_errs", 32'({a_pe, a_fe, a_oe}), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Good frame A5, consumer ready: valid for exactly one cycle.
      Q_ready = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b0, K_WORD, 1'b0);
      @(negedge clk);
      check("t1_valid_drop", 32'(a_valid), 32'd0);

      // Wrong parity bit.
      send_frame(8'hA5, 1'b1, 1'b0, K_PAR, 1'b0);
      check("t2_no_valid", 32'(a_valid), 32'd0);

      // Bad stop bit, then an immediate frame: the stop 1 is not a start.
      send_frame(8'h3C, 1'b0, 1'b1, K_FRM, 1'b0);
      send_frame(8'h01, 1'b0, 1'b0, K_WORD, 1'b0);
      @(negedge clk);

      // Back-to-back frames against a stalled consumer.
      Q_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, K_WORD, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, K_OVR, 1'b0);
      check("t4_held_data", 32'(a_data), 32'h11);
      check("t4_held_valid", 32'(a_valid), 32'd1);
      Q_ready = 1'b1;
      @(negedge clk);
      check("t4_valid_fall", 32'(a_valid), 32'd0);
      Q_ready = 1'b0;

      // Drain coincides with second frame's stop cycle: reload, no overrun.
      send_frame(8'h11, 1'b0, 1'b0, K_WORD, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, K_WORD, 1'b1);
      @(negedge clk);
      check("t5_valid_held", 32'(a_valid), 32'd1);
      check("t5_data", 32'(a_data), 32'h22);
      Q_ready = 1'b1;
      @(negedge clk);
      Q_ready = 1'b0;

      // Held word plus a frame in progress, then asynchronous reset in DATA.
      send_frame(8'h5A, 1'b0, 1'b0, K_WORD, 1'b0);
      part = 8'hC3;
      D = 1'b1;
      @(negedge clk);
      for (int i = 7; i >= 5; i--) begin
         D = part[i];
         @(negedge clk);
      end
      D = part[4];
      check("t6_busy_before", 32'(a_busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("t6_busy", 32'({a_busy, b_busy}), 32'd0);
      check("t6_valid", 32'({a_valid, b_valid}), 32'd0);
      check("t6_data", 32'(a_data), 32'd0);
      check("t6_data_lsb", 32'(b_data), 32'd0);
      D = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      Q_ready = 1'b1;
      send_frame(8'hFF, 1'b0, 1'b0, K_WORD, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b0, K_WORD, 1'b0);
      send_frame(8'h1E, 1'b0, 1'b0, K_WORD, 1'b0);

      repeat (20) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
